// File: rtl/receptor_spi_if.sv
// rtl/receptor_spi_if.sv - handshake/bus bundle for the SPI receive engine (RX_DESBORDE_EN adds desborde_o)
interface receptor_spi_if;
    logic       start_i;
    logic [7:0] n_bytes_i;
    logic       miso_i;
    logic       sclk_o;
    logic       cs_o;
    logic [7:0] dato_o;
    logic       we_o;
    logic [7:0] direccion_o;
    logic       busy_o;
    logic       rx_done_o;
`ifdef RX_DESBORDE_EN
    logic       desborde_o;

    modport master (
        output start_i, n_bytes_i, miso_i,
        input  sclk_o, cs_o, dato_o, we_o, direccion_o, busy_o, rx_done_o, desborde_o
    );
    modport slave (
        input  start_i, n_bytes_i, miso_i,
        output sclk_o, cs_o, dato_o, we_o, direccion_o, busy_o, rx_done_o, desborde_o
    );
`else
    modport master (
        output start_i, n_bytes_i, miso_i,
        input  sclk_o, cs_o, dato_o, we_o, direccion_o, busy_o, rx_done_o
    );
    modport slave (
        input  start_i, n_bytes_i, miso_i,
        output sclk_o, cs_o, dato_o, we_o, direccion_o, busy_o, rx_done_o
    );
`endif
endinterface

// File: rtl/receptor_spi.sv
// rtl/receptor_spi.sv - SPI mode-0 receiver writing bytes to sequential addresses (RX_DESBORDE_EN: sticky wrap flag)
module receptor_spi #(
    parameter int DIV_SCLK = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    receptor_spi_if.slave      bus
);
    typedef enum logic [2:0] {IDLE, SELECT, SHIFT, STORE, DONE} state_t;

    localparam logic [7:0] DIV_FULL = 8'(DIV_SCLK);
    localparam logic [7:0] DIV_LAST = 8'(DIV_SCLK - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [4:0] half;
    logic [8:0] remaining;
    logic [7:0] shreg;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state           <= IDLE;
            cnt             <= '0;
            half            <= '0;
            remaining       <= '0;
            shreg           <= '0;
            bus.sclk_o      <= 1'b0;
            bus.cs_o        <= 1'b1;
            bus.dato_o      <= '0;
            bus.we_o        <= 1'b0;
            bus.direccion_o <= '0;
            bus.busy_o      <= 1'b0;
            bus.rx_done_o   <= 1'b0;
`ifdef RX_DESBORDE_EN
            bus.desborde_o  <= 1'b0;
`endif
        end else begin
            bus.we_o      <= 1'b0;
            bus.rx_done_o <= 1'b0;
            // Address advances the cycle after each strobe, so it reads as the write address during we_o
            if (bus.we_o) begin
                bus.direccion_o <= bus.direccion_o + 8'd1;
`ifdef RX_DESBORDE_EN
                if (bus.direccion_o == 8'hFF)
                    bus.desborde_o <= 1'b1;
`endif
            end
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        state      <= SELECT;
                        bus.cs_o   <= 1'b0;
                        bus.busy_o <= 1'b1;
                        cnt        <= '0;
                        remaining  <= (bus.n_bytes_i == 8'd0) ? 9'd256 : {1'b0, bus.n_bytes_i};
                    end
                end
                SELECT: begin
                    if (cnt == DIV_FULL) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        half  <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (half == 5'd16) begin
                        state      <= STORE;
                        bus.we_o   <= 1'b1;
                        bus.dato_o <= shreg;
                        remaining  <= remaining - 9'd1;
                    end else if (cnt == DIV_LAST) begin
                        cnt        <= '0;
                        half       <= half + 5'd1;
                        bus.sclk_o <= ~bus.sclk_o;
                        if (!bus.sclk_o)
                            shreg <= {shreg[6:0], bus.miso_i};
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                STORE: begin
                    if (remaining == 9'd0) begin
                        state         <= DONE;
                        bus.cs_o      <= 1'b1;
                        bus.rx_done_o <= 1'b1;
                        bus.busy_o    <= 1'b0;
                    end else begin
                        state <= SHIFT;
                        cnt   <= '0;
                        half  <= '0;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/receptor_spi.md
RECEPTOR_SPI -- requirements
Module: receptor_spi

Interface
REQ-001 Parameter DIV_SCLK, default 4, meaning system-clock cycles per SCLK half-period; legal range 2..255.
REQ-002 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 start_i  input  1  one-cycle pulse requesting a receive transaction.
REQ-005 n_bytes_i  input  8  bytes to receive; 0 encodes 256; sampled on accepted start_i.
REQ-006 miso_i  input  1  serial data from slave.
REQ-007 sclk_o  output  1  SPI clock, mode 0 (idle low).
REQ-008 cs_o  output  1  slave select, active low.
REQ-009 dato_o  output  8  last received byte.
REQ-010 we_o  output  1  one-cycle write strobe, qualifies dato_o and direccion_o.
REQ-011 direccion_o  output  8  memory address for the current write.
REQ-012 busy_o  output  1  high from accepted start_i until rx_done_o.
REQ-013 rx_done_o  output  1  one-cycle pulse when the transaction completes.

Function
REQ-014 FSM states: IDLE, SELECT, SHIFT, STORE, DONE.
REQ-015 IDLE->SELECT when start_i=1; start_i while busy_o=1 is ignored.
REQ-016 SELECT: cs_o low, sclk_o low, held DIV_SCLK cycles, then ->SHIFT.
REQ-017 SHIFT: sclk_o toggles every DIV_SCLK cycles; miso_i sampled on the clk_i cycle producing sclk_o rising; MSB first.
REQ-018 After the 8th rising SCLK edge and its following falling edge, ->STORE.
REQ-019 STORE: exactly one cycle; dato_o updated, we_o=1, direccion_o holds the write address.
REQ-020 direccion_o increments by 1 on the cycle after each we_o; 255 wraps to 0.
REQ-021 Address counter persists across transactions; cleared only by reset.
REQ-022 STORE->SHIFT if bytes remain, else ->DONE; no extra CS deassertion between bytes.
REQ-023 DONE: cs_o high, rx_done_o=1 for one cycle, ->IDLE.
REQ-024 Latency from start_i to first we_o: DIV_SCLK*17 + 2 cycles.
REQ-025 dato_o holds its value between strobes.

Reset
REQ-026 On reset_i: state IDLE, sclk_o=0, cs_o=1, dato_o=0, we_o=0, direccion_o=0, busy_o=0, rx_done_o=0.
REQ-027 Reset mid-transaction aborts immediately; no we_o or rx_done_o is emitted for the partial byte.
REQ-028 First start_i accepted on the first clk_i edge after reset_i deasserts.

Configuration
REQ-029 Macro RX_DESBORDE_EN: when defined, adds output desborde_o (1 bit), set sticky on the we_o that occurs at direccion_o=255, cleared only by reset; it resets to 0.
REQ-030 Without RX_DESBORDE_EN the port does not exist and wrap-around is silent.

Verification
REQ-031 Reset, start_i, n_bytes_i=1, MISO sends 0xA5 -> one we_o with dato_o=0xA5, direccion_o=0, then rx_done_o; direccion_o=1 afterwards.
REQ-032 n_bytes_i=3, bytes 0x01,0x80,0xFF -> three we_o at addresses 0,1,2; cs_o low continuously until DONE.
REQ-033 start_i pulsed again during SHIFT -> ignored; exactly n_bytes_i strobes total.
REQ-034 n_bytes_i=0 -> 256 strobes, addresses 0..255, direccion_o=0 at end; with RX_DESBORDE_EN desborde_o=1.
REQ-035 reset_i asserted after 4 SCLK rising edges -> cs_o=1, sclk_o=0, no we_o, direccion_o=0 at once.
REQ-036 DIV_SCLK=2, n_bytes_i=1 -> first we_o exactly 36 cycles after start_i.
